// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one pipelined 48-bit XOR unit between N_REQ requesters.
// Issue stage registers operands; a tag pipe tracks ids through the unit's fixed latency.
module xor_unit_arbiter #(
   parameter  int N_REQ       = 4,
   parameter  int XOR_LATENCY = 3,
   parameter  int MAX_OUT     = 2,
   localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW          = $clog2(MAX_OUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [48*N_REQ-1:0]   req_one,
   input  logic [48*N_REQ-1:0]   req_two,
   output logic [47:0]           xor_one,
   output logic [47:0]           xor_two,
   input  logic [47:0]           xor_res,
   output logic                  res_valid,
   output logic [IDW-1:0]        res_id,
   output logic [47:0]           res_data,
   output logic                  busy
);

   logic [IDW-1:0]   ptr;
   logic [CW-1:0]    outst [N_REQ];
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] retire;
   logic             gnt;
   logic [IDW-1:0]   gnt_id;
   int               idx;

   logic             vld_p0;
   logic [IDW-1:0]   id_p0;
   logic [XOR_LATENCY-1:0] vld_pipe;
   logic [IDW-1:0]   id_pipe [XOR_LATENCY];

   // A retiring result frees its slot in the same cycle, allowing back-to-back regrant.
   always_comb begin
      retire = '0;
      elig   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         retire[i] = res_valid && (res_id == IDW'(i));
         elig[i]   = req_valid[i] && !hold && !rst &&
                     ((outst[i] < CW'(MAX_OUT)) || retire[i]);
      end
   end

   always_comb begin
      gnt    = 1'b0;
      gnt_id = '0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!gnt && elig[idx]) begin
            gnt    = 1'b1;
            gnt_id = IDW'(idx);
         end
      end
      req_ready = gnt ? (N_REQ'(1) << gnt_id) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (gnt) begin
         ptr <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + IDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (rst) begin
            outst[i] <= '0;
         end else begin
            if ((gnt && gnt_id == IDW'(i)) && !(retire[i] && outst[i] != '0)) begin
               outst[i] <= outst[i] + CW'(1);
            end else if (!(gnt && gnt_id == IDW'(i)) && (retire[i] && outst[i] != '0)) begin
               outst[i] <= outst[i] - CW'(1);
            end
         end
      end
   end

   // p0: issue register feeding the XOR unit
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         id_p0   <= '0;
         xor_one <= '0;
         xor_two <= '0;
      end else begin
         vld_p0 <= gnt;
         if (gnt) begin
            id_p0   <= gnt_id;
            xor_one <= req_one[int'(gnt_id)*48 +: 48];
            xor_two <= req_two[int'(gnt_id)*48 +: 48];
         end
      end
   end

   // p1..pL: tag pipe matching the unit latency; last stage is the result tag
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         for (int k = 0; k < XOR_LATENCY; k++) id_pipe[k] <= '0;
      end else begin
         vld_pipe[0] <= vld_p0;
         id_pipe[0]  <= id_p0;
         for (int k = 1; k < XOR_LATENCY; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            id_pipe[k]  <= id_pipe[k-1];
         end
      end
   end

   assign res_valid = vld_pipe[XOR_LATENCY-1];
   assign res_id    = id_pipe[XOR_LATENCY-1];
   assign res_data  = xor_res;
   assign busy      = vld_p0 | (|vld_pipe);

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Scoreboard bench for xor_unit_arbiter: transaction-level reference model drives
// expected grants, a separate monitor checks every returned result.
module tb_xor_unit_arbiter;
   localparam int N    = 4;
   localparam int L    = 3;
   localparam int MAXO = 2;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst, hold;
   logic [N-1:0]      req_valid, req_ready;
   logic [48*N-1:0]   req_one, req_two;
   logic [47:0]       xor_one, xor_two, xor_res, res_data;
   logic              res_valid;
   logic [IDW-1:0]    res_id;
   logic              busy;

   always #5 clk = ~clk;

   xor_unit_arbiter #(.N_REQ(N), .XOR_LATENCY(L), .MAX_OUT(MAXO)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_one(req_one), .req_two(req_two),
      .xor_one(xor_one), .xor_two(xor_two), .xor_res(xor_res),
      .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
      .busy(busy)
   );

   // stand-in for the pipelined XOR unit
   logic [47:0] u0, u1, u2;
   always @(posedge clk) begin
      u0 <= xor_one ^ xor_two;
      u1 <= u0;
      u2 <= u1;
   end
   assign xor_res = u2;

   typedef struct {
      int          id;
      logic [47:0] data;
      int          due;
   } ent_t;

   ent_t        sbq[$];
   ent_t        retq[$];
   int          cnt[N];
   int          mptr;
   int          cyc;
   int          checks;
   int          passes;
   logic        iss_chk;
   logic [47:0] iss_one, iss_two;
   logic        mon_en;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (res_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 64'(res_valid), 64'd0);
            end else begin
               ent_t e;
               e = sbq.pop_front();
               chk("res_id", 64'(res_id), 64'(e.id));
               chk("res_data", 64'(res_data), 64'(e.data));
               chk("res_time", 64'(cyc), 64'(e.due));
            end
         end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            chk("missing_result", 64'(res_valid), 64'd1);
            void'(sbq.pop_front());
         end
      end
   end

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_one[48*i +: 48] = 48'({$urandom(), $urandom()});
         req_two[48*i +: 48] = 48'({$urandom(), $urandom()});
      end
   endtask

   // One clock: drive, predict and compare at negedge, advance model at posedge.
   task automatic step(input logic [N-1:0] v, input logic h, input logic r);
      logic [N-1:0] exp_rdy;
      int   g;
      int   ret_id;
      logic ret;
      int   eff;
      int   i;
      ent_t e;
      req_valid = v;
      hold      = h;
      rst       = r;
      @(negedge clk);
      ret    = (retq.size() != 0) && (retq[0].due == cyc);
      ret_id = ret ? retq[0].id : -1;
      g      = -1;
      for (int k = 0; k < N; k++) begin
         i   = (mptr + k) % N;
         eff = cnt[i] - ((i == ret_id) ? 1 : 0);
         if (g < 0 && v[i] && !h && !r && eff < MAXO) g = i;
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(retq.size() != 0));
      if (iss_chk) begin
         chk("xor_one", 64'(xor_one), 64'(iss_one));
         chk("xor_two", 64'(xor_two), 64'(iss_two));
      end
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < N; k++) cnt[k] = 0;
         mptr    = 0;
         iss_chk = 1'b0;
         retq.delete();
         sbq.delete();
      end else begin
         if (ret) begin
            void'(retq.pop_front());
            cnt[ret_id]--;
         end
         iss_chk = (g >= 0);
         if (g >= 0) begin
            cnt[g]++;
            mptr    = (g + 1) % N;
            iss_one = req_one[48*g +: 48];
            iss_two = req_two[48*g +: 48];
            e.id    = g;
            e.data  = iss_one ^ iss_two;
            e.due   = cyc + 1 + L;
            retq.push_back(e);
            sbq.push_back(e);
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      hold      = 1'b0;
      req_valid = '0;
      req_one   = '0;
      req_two   = '0;
      mon_en    = 1'b0;
      iss_chk   = 1'b0;
      mptr      = 0;
      cyc       = 0;
      checks    = 0;
      passes    = 0;
      for (int k = 0; k < N; k++) cnt[k] = 0;
      @(posedge clk);
      #1;
      repeat (3) step('0, 1'b0, 1'b1);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_id", 64'(res_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_xor_one", 64'(xor_one), 64'd0);
      chk("rst_xor_two", 64'(xor_two), 64'd0);
      mon_en = 1'b1;

      // single requester with known operands
      req_one[47:0] = 48'hFFFF_0000_FFFF;
      req_two[47:0] = 48'h0F0F_0F0F_0F0F;
      step(4'b0001, 1'b0, 1'b0);
      chk("single_expected_xor", 64'(sbq.size() != 0 ? sbq[0].data : 48'h0), 64'h0000_F0F0_0F0F_F0F0);
      repeat (6) step('0, 1'b0, 1'b0);

      // all requesters continuously valid
      repeat (16) begin rand_ops(); step(4'b1111, 1'b0, 1'b0); end
      repeat (6) step('0, 1'b0, 1'b0);

      // outstanding limit on a single requester
      repeat (10) begin rand_ops(); step(4'b0100, 1'b0, 1'b0); end
      repeat (6) step('0, 1'b0, 1'b0);

      // hold with requests pending and ops in flight
      repeat (3) begin rand_ops(); step(4'b1010, 1'b0, 1'b0); end
      repeat (5) begin rand_ops(); step(4'b1010, 1'b1, 1'b0); end
      repeat (4) begin rand_ops(); step(4'b1010, 1'b0, 1'b0); end
      repeat (6) step('0, 1'b0, 1'b0);

      // reset with operations in flight
      repeat (3) begin rand_ops(); step(4'b1111, 1'b0, 1'b0); end
      step(4'b1111, 1'b0, 1'b1);
      repeat (4) begin rand_ops(); step(4'b1110, 1'b0, 1'b0); end
      repeat (6) step('0, 1'b0, 1'b0);

      // random stress
      repeat (10000) begin
         rand_ops();
         step(N'($urandom()), ($urandom_range(0, 7) == 0), ($urandom_range(0, 499) == 0));
      end
      repeat (8) step('0, 1'b0, 1'b0);
      chk("drain_empty", 64'(sbq.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
